// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and constants for the I2C read master
//
// Contents:
//   i2c_mstate_t      master FSM state encoding
//   I2C_RD / I2C_WR   R/W bit values appended to the 7-bit address
//   I2C_DEFAULT_ADDR  default target address (7'h64)
package i2c_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_ADDR_ACK,
        S_READ,
        S_MACK,
        S_STOP,
        S_FINISH
    } i2c_mstate_t;

    localparam logic       I2C_RD           = 1'b1;
    localparam logic       I2C_WR           = 1'b0;
    localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h64;

endpackage

// File: rtl/i2c_quarter_tick.sv
// rtl/i2c_quarter_tick.sv - SCL quarter-period tick generator
//
// Ports:
//   clk, rst_n  system clock, asynchronous active-low reset
//   clear       restart the period from zero (used when a transaction starts)
//   hold        freeze the counter (SCL stretched by a slave)
//   tick        one-cycle pulse every CLK_DIV unheld cycles
module i2c_quarter_tick #(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic hold,
    output logic tick
);

    localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

    logic [7:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else if (!hold) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign tick = (cnt == LAST) && !hold;

endmodule

// File: rtl/i2c_read_master.sv
// rtl/i2c_read_master.sv - I2C master reading a 3-byte position record
//
// Each accepted start runs: START, {TARGET_ADDR, R}, address ACK check,
// three data bytes (ACK, ACK, NACK), STOP, then a one-cycle done pulse.
// Optional macro I2C_READ_MASTER_STRETCH_EN: honour slave clock stretching
// (scl_in is otherwise unused).
//
// Ports:
//   clk, rst_n              system clock, asynchronous active-low reset
//   start                   single-cycle request, ignored while busy
//   busy                    transaction in progress
//   done                    one-cycle end-of-transaction pulse
//   nack_err                address was not acknowledged (valid with done)
//   x_pos, y_pos, status    last good read results
//   scl_in, sda_in          raw pad levels
//   scl_oe, sda_oe          1 = pull line low
//   sda_out                 constant 0 (open-drain data)
module i2c_read_master
    import i2c_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = I2C_DEFAULT_ADDR,
    parameter int         CLK_DIV     = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       nack_err,
    output logic [7:0] x_pos,
    output logic [7:0] y_pos,
    output logic [7:0] status,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl_oe,
    output logic       sda_oe,
    output logic       sda_out
);

    localparam logic [7:0] ADDR_BYTE = {TARGET_ADDR, I2C_RD};

    i2c_mstate_t state;
    logic [1:0]  q;
    logic [2:0]  bit_cnt;
    logic [2:0]  bit_nxt;
    logic [1:0]  byte_idx;
    logic [7:0]  shreg;
    logic [7:0]  stg0, stg1, stg2;
    logic        nack;
    logic        tick;
    logic        hold;
    logic        clear;
    logic [1:0]  sda_sync;
    logic        sda_s;

    assign sda_out = 1'b0;
    assign bit_nxt = bit_cnt + 3'd1;
    assign clear   = (state == S_IDLE) && start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sda_sync <= 2'b11;
        else        sda_sync <= {sda_sync[0], sda_in};
    end
    assign sda_s = sda_sync[1];

`ifdef I2C_READ_MASTER_STRETCH_EN
    logic [1:0] scl_sync;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) scl_sync <= 2'b11;
        else        scl_sync <= {scl_sync[0], scl_in};
    end
    // SCL released but still seen low: a slave is stretching, stall the quarter.
    assign hold = !scl_oe && !scl_sync[1];
`else
    logic unused_scl;
    assign unused_scl = scl_in;
    assign hold       = 1'b0;
`endif

    i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .hold  (hold),
        .tick  (tick)
    );

    // Bit states share one quarter sequence: Q2 entry releases SCL, Q3 entry
    // samples SDA, and the wrap to the next Q0 pulls SCL low and sets up the
    // SDA level of whichever bit comes next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            q        <= '0;
            bit_cnt  <= '0;
            byte_idx <= '0;
            shreg    <= '0;
            stg0     <= '0;
            stg1     <= '0;
            stg2     <= '0;
            nack     <= 1'b0;
            scl_oe   <= 1'b0;
            sda_oe   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            nack_err <= 1'b0;
            x_pos    <= '0;
            y_pos    <= '0;
            status   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_START;
                        busy     <= 1'b1;
                        q        <= '0;
                        nack     <= 1'b0;
                        bit_cnt  <= '0;
                        byte_idx <= '0;
                    end
                end
                S_START: begin
                    if (tick) begin
                        q <= q + 2'd1;
                        case (q)
                            2'd0: sda_oe <= 1'b1;
                            2'd2: scl_oe <= 1'b1;
                            2'd3: begin
                                // SCL has been low a full quarter before data moves.
                                state  <= S_ADDR;
                                sda_oe <= ~ADDR_BYTE[7];
                            end
                            default: ;
                        endcase
                    end
                end
                S_ADDR, S_ADDR_ACK, S_READ, S_MACK: begin
                    if (tick) begin
                        q <= q + 2'd1;
                        case (q)
                            2'd1: scl_oe <= 1'b0;
                            2'd2: begin
                                if (state == S_ADDR_ACK) nack  <= sda_s;
                                if (state == S_READ)     shreg <= {shreg[6:0], sda_s};
                            end
                            2'd3: begin
                                scl_oe <= 1'b1;
                                case (state)
                                    S_ADDR: begin
                                        if (bit_cnt == 3'd7) begin
                                            state   <= S_ADDR_ACK;
                                            bit_cnt <= '0;
                                            sda_oe  <= 1'b0;
                                        end else begin
                                            bit_cnt <= bit_nxt;
                                            sda_oe  <= ~ADDR_BYTE[3'd7 - bit_nxt];
                                        end
                                    end
                                    S_ADDR_ACK: begin
                                        if (nack) begin
                                            state  <= S_STOP;
                                            sda_oe <= 1'b1;
                                        end else begin
                                            state    <= S_READ;
                                            byte_idx <= '0;
                                            sda_oe   <= 1'b0;
                                        end
                                    end
                                    S_READ: begin
                                        if (bit_cnt == 3'd7) begin
                                            state   <= S_MACK;
                                            bit_cnt <= '0;
                                            case (byte_idx)
                                                2'd0:    stg0 <= shreg;
                                                2'd1:    stg1 <= shreg;
                                                default: stg2 <= shreg;
                                            endcase
                                            // ACK the first two bytes, NACK the last.
                                            sda_oe <= (byte_idx != 2'd2);
                                        end else begin
                                            bit_cnt <= bit_nxt;
                                            sda_oe  <= 1'b0;
                                        end
                                    end
                                    default: begin
                                        if (byte_idx != 2'd2) begin
                                            state    <= S_READ;
                                            byte_idx <= byte_idx + 2'd1;
                                            sda_oe   <= 1'b0;
                                        end else begin
                                            state  <= S_STOP;
                                            sda_oe <= 1'b1;
                                        end
                                    end
                                endcase
                            end
                            default: ;
                        endcase
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        q <= q + 2'd1;
                        case (q)
                            2'd1: scl_oe <= 1'b0;
                            2'd3: begin
                                sda_oe <= 1'b0;
                                state  <= S_FINISH;
                            end
                            default: ;
                        endcase
                    end
                end
                S_FINISH: begin
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    nack_err <= nack;
                    if (!nack) begin
                        x_pos  <= stg0;
                        y_pos  <= stg1;
                        status <= stg2;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_read_master.sv
// tb/tb_i2c_read_master.sv - scoreboard bench with a behavioural I2C slave
module tb_i2c_read_master;

    localparam int         DIV   = 8;
    localparam logic [6:0] TADDR = 7'h64;

    logic       clk = 1'b0;
    logic       rst_n, start;
    logic       busy, done, nack_err;
    logic [7:0] x_pos, y_pos, status;
    logic       scl_in, sda_in, scl_oe, sda_oe, sda_out;
    logic       scl_line, sda_line;
    logic       sl_sda_oe, sl_hold;

    int checks = 0, failures = 0;
    int cyc = 0, done_cnt = 0, issued = 0;

    logic [24:0] exp_q[$];
    logic [7:0]  m_x = 8'h00, m_y = 8'h00, m_st = 8'h00;

    logic [6:0] sl_addr;
    logic [7:0] sl_data [3];
    int         sl_starts = 0, sl_stops = 0;
    int         sl_frame, sl_bitn, sl_byte, ack_cnt;
    logic [2:0] ack_bits;
    logic       sl_active, sl_addressed, sl_last_ack;
    logic [7:0] sl_sh, sl_cur;
    logic       ps, pd, s_now, d_now;
    bit         st_en = 0;
    int         hold_left = 0, hold_start = 0;
    bit         stretch_pending = 0;

    assign scl_line = ~scl_oe & ~sl_hold;
    assign sda_line = ~sda_oe & ~sl_sda_oe;
    assign scl_in   = scl_line;
    assign sda_in   = sda_line;

    i2c_read_master #(.TARGET_ADDR(TADDR), .CLK_DIV(DIV)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .nack_err(nack_err), .x_pos(x_pos), .y_pos(y_pos), .status(status),
        .scl_in(scl_in), .sda_in(sda_in), .scl_oe(scl_oe), .sda_oe(sda_oe),
        .sda_out(sda_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h @cyc %0d", name, act, exp, cyc);
        end
    endtask

    // Behavioural slave: reacts to line edges seen at clk granularity.
    always @(negedge clk) begin
        if (!rst_n) begin
            sl_active = 0; sl_sda_oe = 0; sl_hold = 0; ps = 1; pd = 1;
            hold_left = 0; stretch_pending = 0;
        end else begin
            s_now = scl_line;
            d_now = sda_line;
            if (ps && s_now && pd && !d_now) begin
                sl_starts++; sl_active = 1; sl_frame = 0; sl_bitn = 0; sl_sh = 0;
                ack_cnt = 0; ack_bits = 0; sl_sda_oe = 0;
            end else if (ps && s_now && !pd && d_now) begin
                sl_stops++; sl_active = 0; sl_sda_oe = 0;
            end else if (sl_active && !ps && s_now) begin
                if (sl_frame == 0 && sl_bitn < 8) sl_sh = {sl_sh[6:0], d_now};
                if (sl_frame == 1 && sl_bitn == 8) begin
                    ack_bits = {ack_bits[1:0], d_now}; ack_cnt++; sl_last_ack = d_now;
                end
`ifdef I2C_READ_MASTER_STRETCH_EN
                if (stretch_pending) begin
                    chk("stretch_delay", (cyc - hold_start) >= 100, 1'b1);
                    stretch_pending = 0;
                end
`endif
                sl_bitn++;
            end else if (sl_active && ps && !s_now) begin
                if (sl_frame == 0) begin
                    if (sl_bitn == 8) begin
                        sl_addressed = (sl_sh == {sl_addr, 1'b1});
                        sl_sda_oe = sl_addressed;
                    end else if (sl_bitn == 9) begin
                        if (sl_addressed) begin
                            sl_frame = 1; sl_bitn = 0; sl_byte = 0;
                            sl_cur = sl_data[0]; sl_sda_oe = !sl_cur[7];
                        end else begin
                            sl_active = 0; sl_sda_oe = 0;
                        end
                    end
                end else begin
                    if (sl_bitn >= 1 && sl_bitn <= 7) begin
                        sl_cur = sl_data[sl_byte]; sl_sda_oe = !sl_cur[7 - sl_bitn];
`ifdef I2C_READ_MASTER_STRETCH_EN
                        if (st_en && sl_byte == 1 && sl_bitn == 3) begin
                            sl_hold = 1; hold_left = 100; hold_start = cyc; stretch_pending = 1;
                        end
`endif
                    end else if (sl_bitn == 8) begin
                        sl_sda_oe = 0;
                    end else if (sl_bitn == 9) begin
                        sl_byte++; sl_bitn = 0;
                        if (!sl_last_ack && sl_byte < 3) begin
                            sl_cur = sl_data[sl_byte]; sl_sda_oe = !sl_cur[7];
                        end else begin
                            sl_sda_oe = 0; sl_active = 0;
                        end
                    end
                end
            end
            if (hold_left > 0) begin
                hold_left--;
                if (hold_left == 0) sl_hold = 0;
            end
            ps = s_now;
            pd = d_now;
        end
    end

    // Monitor: pops the scoreboard on every done pulse and watches SCL timing.
    logic [24:0] e;
    logic        mprev_scl = 1'b1;
    bit          have_rise = 0;
    int          last_rise = 0, snap_starts = 0, snap_stops = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            have_rise = 0; mprev_scl = 1'b1;
            snap_starts = sl_starts; snap_stops = sl_stops;
        end else begin
            if (scl_line && !mprev_scl && busy) begin
`ifndef I2C_READ_MASTER_STRETCH_EN
                if (have_rise) chk("scl_period", cyc - last_rise, 4 * DIV);
`endif
                have_rise = 1; last_rise = cyc;
            end
            mprev_scl = scl_line;
            if (done) begin
                done_cnt++;
                have_rise = 0;
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 0, 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("nack_err", nack_err, e[24]);
                    chk("x_pos", x_pos, e[23:16]);
                    chk("y_pos", y_pos, e[15:8]);
                    chk("status", status, e[7:0]);
                    chk("ack_pattern", ack_cnt * 8 + ack_bits, e[24] ? 0 : 3 * 8 + 1);
                    chk("start_conds", sl_starts - snap_starts, 1);
                    chk("stop_conds", sl_stops - snap_stops, 1);
                end
                snap_starts = sl_starts; snap_stops = sl_stops;
            end
        end
    end

    task automatic run_txn(input logic [6:0] a, input logic [7:0] dx, input logic [7:0] dy,
                           input logic [7:0] ds, input bit dup);
        int n, target;
        logic en;
        sl_addr = a; sl_data[0] = dx; sl_data[1] = dy; sl_data[2] = ds;
        target = done_cnt + 1;
        @(posedge clk); #1 start = 1'b1;
        if (a == TADDR) begin
            m_x = dx; m_y = dy; m_st = ds; en = 1'b0;
        end else begin
            en = 1'b1;
        end
        exp_q.push_back({en, m_x, m_y, m_st});
        issued++;
        @(posedge clk); #1 start = 1'b0;
        chk("busy_after_start", busy, 1'b1);
        if (dup) begin
            repeat ($urandom_range(50, 400)) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        n = 0;
        while (done_cnt < target && n < 5000) begin
            @(posedge clk); n++;
        end
        chk("done_timeout", n < 5000, 1'b1);
        repeat (3) @(posedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b0; start = 1'b0;
        sl_addr = TADDR; sl_data[0] = 0; sl_data[1] = 0; sl_data[2] = 0;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_scl_oe", scl_oe, 1'b0);
        chk("rst_sda_oe", sda_oe, 1'b0);
        chk("rst_sda_out", sda_out, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_nack_err", nack_err, 1'b0);
        chk("rst_data", {x_pos, y_pos, status}, 24'h0);
        rst_n = 1'b1;

        run_txn(7'h64, 8'h12, 8'hA5, 8'h80, 1'b0);
        run_txn(7'h65, 8'h55, 8'h66, 8'h77, 1'b0);
        run_txn(7'h64, 8'h3C, 8'hC3, 8'h01, 1'b1);
`ifdef I2C_READ_MASTER_STRETCH_EN
        st_en = 1;
        run_txn(7'h64, 8'h12, 8'hA5, 8'h80, 1'b0);
        st_en = 0;
`endif

        // Reset in the middle of the second data byte.
        sl_addr = TADDR; sl_data[0] = 8'h9A; sl_data[1] = 8'hBC; sl_data[2] = 8'hDE;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 0;
        while (!(sl_active && sl_frame == 1 && sl_byte == 1) && n < 5000) begin
            @(posedge clk); n++;
        end
        chk("reach_read", n < 5000, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_scl_oe", scl_oe, 1'b0);
        chk("midrst_sda_oe", sda_oe, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_data", {x_pos, y_pos, status, nack_err}, 25'h0);
        m_x = 0; m_y = 0; m_st = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);

        for (int i = 0; i < 8; i++) begin
            logic [6:0] a;
            a = ($urandom_range(0, 3) == 0) ? (TADDR ^ 7'($urandom_range(1, 127))) : TADDR;
            run_txn(a, 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
        end

        repeat (20) @(posedge clk);
        chk("done_count", done_cnt, issued);
        chk("pending_expect", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
